// File: rtl/storemem.sv
// Read-modify-write store unit: inserts SB/SH data into a word RAM without byte
// enables, or writes SW words directly. Misaligned or unknown stores are rejected.
module storemem #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [A_WIDTH-1:0] st_addr,
    input  logic [D_WIDTH-1:0] st_data,
    input  logic [2:0]         st_mode,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic               mem_re,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic               st_done,
    output logic               st_misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [1:0]         lane_q, lane_d;
    logic [1:0]         mode_q, mode_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic [A_WIDTH-1:0] maddr_q, maddr_d;
    logic               accept;
    logic               misalign;
    logic [D_WIDTH-1:0] merged;

    assign accept = st_valid && (state_q == S_IDLE);

    always_comb begin
        misalign = 1'b1;
        case (st_mode)
            3'b000:  misalign = 1'b0;
            3'b001:  misalign = st_addr[0];
            3'b010:  misalign = (st_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // Only the low address bits and the size are needed after acceptance; the
    // word address lives in maddr_q, which an ERR request leaves untouched.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        mode_d  = mode_q;
        data_d  = data_q;
        maddr_d = maddr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    lane_d = st_addr[1:0];
                    mode_d = st_mode[1:0];
                    data_d = st_data;
                    if (misalign) begin
                        state_d = S_ERR;
                    end else begin
                        maddr_d = {st_addr[A_WIDTH-1:2], 2'b00};
                        state_d = (st_mode == 3'b010) ? S_WR : S_RD;
                    end
                end
            end
            S_RD:    state_d = S_WR;
            S_WR:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            mode_q  <= '0;
            data_q  <= '0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            maddr_q <= maddr_d;
        end
    end

    always_comb begin
        merged = mem_rdata;
        case (mode_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]     = data_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
            default: merged = data_q;
        endcase
    end

    // Strobes decode straight from the state register so reset kills them at once.
    assign st_ready    = (state_q == S_IDLE);
    assign mem_re      = (state_q == S_RD);
    assign mem_we      = (state_q == S_WR);
    assign st_done     = (state_q == S_WR);
    assign st_misalign = (state_q == S_ERR);
    assign mem_addr    = maddr_q;
    assign mem_wdata   = (state_q == S_WR) ? merged : '0;

endmodule

// File: doc/storemem.md
STOREMEM -- requirements
Module: storemem

Interface
REQ-001 The block SHALL have parameter D_WIDTH, default 32, which sets the data word width and is fixed at 32 for RV32.
REQ-002 The block SHALL have parameter A_WIDTH, default 32, which sets the byte-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port st_valid, input, 1 bit: store request valid.
REQ-006 The block SHALL have port st_ready, output, 1 bit: block can accept a request.
REQ-007 The block SHALL have port st_addr, input, A_WIDTH bits: byte address of the store.
REQ-008 The block SHALL have port st_data, input, D_WIDTH bits: store data, right-aligned (rs2).
REQ-009 The block SHALL have port st_mode, input, 3 bits: funct3, where 000 = SB, 001 = SH, 010 = SW.
REQ-010 The block SHALL have port mem_addr, output, A_WIDTH bits: word-aligned RAM address, with bits [1:0] always 0.
REQ-011 The block SHALL have port mem_re, output, 1 bit: RAM read strobe.
REQ-012 The block SHALL have port mem_rdata, input, D_WIDTH bits: RAM read data, valid one cycle after mem_re.
REQ-013 The block SHALL have port mem_we, output, 1 bit: RAM full-word write strobe.
REQ-014 The block SHALL have port mem_wdata, output, D_WIDTH bits: merged word to write.
REQ-015 The block SHALL have port st_done, output, 1 bit: one-cycle pulse marking store completion.
REQ-016 The block SHALL have port st_misalign, output, 1 bit: one-cycle pulse marking a rejected store.

Function
REQ-017 The block SHALL be the write-side counterpart of the load extractor: it inserts a byte or halfword into a word-wide RAM that has no byte enables, using read-modify-write.
REQ-018 The FSM SHALL have states IDLE, RD, WR and ERR; st_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on the rising edge where st_valid && st_ready; st_addr, st_data and st_mode SHALL be captured into internal registers at that edge, and inputs SHALL be ignored thereafter until IDLE.
REQ-020 Misalignment SHALL be checked at acceptance: SH with addr[0]=1, SW with addr[1:0]!=00, and st_mode not in {000, 001, 010} SHALL move IDLE->ERR.
REQ-021 An aligned SB or SH SHALL move IDLE->RD.
REQ-022 An aligned SW SHALL move IDLE->WR directly, with no read.
REQ-023 In RD, the block SHALL drive mem_re=1 and mem_addr={addr[A_WIDTH-1:2], 2'b00}, then move RD->WR unconditionally.
REQ-024 In WR, the block SHALL drive mem_we=1, the same mem_addr, and st_done=1 for exactly this cycle, then move WR->IDLE.
REQ-025 Merge for SW: mem_wdata SHALL equal st_data.
REQ-026 Merge for SB: mem_wdata SHALL equal mem_rdata with byte lane addr[1:0] replaced by st_data[7:0].
REQ-027 Merge for SH: mem_wdata SHALL equal mem_rdata with lane addr[1] replaced by st_data[15:0], where lane 0 is bits [15:0] and lane 1 is bits [31:16].
REQ-028 In ERR, the block SHALL drive st_misalign=1 for one cycle with mem_we=0 and mem_re=0, then move ERR->IDLE.
REQ-029 Latency from the accept edge SHALL be: SB/SH done in the 2nd cycle after accept; SW done in the 1st; misaligned rejected in the 1st.
REQ-030 In IDLE, RD and ERR, mem_we SHALL be 0; in any state other than RD, mem_re SHALL be 0.
REQ-031 mem_we and mem_re SHALL never be high in the same cycle.
REQ-032 In IDLE and ERR, mem_wdata SHALL be 0 and mem_addr SHALL hold its last value.
REQ-033 Back-to-back requests SHALL be supported: a new request is accepted in the IDLE cycle that immediately follows WR or ERR; throughput is 1 store per 3 cycles for SB/SH and 1 per 2 cycles for SW.
REQ-034 The block SHALL perform no address-range checking; address bits above [1:0] SHALL pass through unchanged.

Reset
REQ-035 While rst_n=0, regardless of clk: state=IDLE, st_ready=1, mem_re=0, mem_we=0, st_done=0, st_misalign=0, mem_addr=0, mem_wdata=0, and all capture registers=0.
REQ-036 Reset asserted in RD or WR SHALL abort the store; mem_we SHALL drop asynchronously and no partial write SHALL complete.
REQ-037 After rst_n deasserts, the block SHALL accept a request on the first rising edge.

Verification
REQ-038 SB: st_addr=0x103, st_data=0x000000AB; RAM[0x100]=0x11223344 -> cycle 1 mem_re=1, mem_addr=0x100; cycle 2 mem_we=1, mem_wdata=0xAB223344, st_done=1.
REQ-039 SH: st_addr=0x202, st_data=0xFFFFBEEF; RAM[0x200]=0x11223344 -> cycle 2 mem_wdata=0xBEEF3344, mem_we=1.
REQ-040 SW: st_addr=0x300, st_data=0xDEADBEEF -> cycle 1 mem_we=1, mem_wdata=0xDEADBEEF, st_done=1; mem_re stays 0 throughout.
REQ-041 Misaligned: SH to 0x201, SW to 0x302, and st_mode=011 -> each produces st_misalign=1 for 1 cycle with mem_we=0 and mem_re=0, and RAM is unchanged.
REQ-042 Reset mid-store: SB accepted, rst_n=0 during WR -> mem_we falls immediately, st_ready=1, and RAM is unchanged.
REQ-043 Back-to-back: SB, SW, SH with st_valid held high -> accept edges at cycles 0, 3 and 5, and st_done pulses at cycles 2, 4 and 7.
